cache_param: RTL and testbench



---
 rtl/cache_param_if.sv | 31 +++
 rtl/cache_param.sv | 209 ++++++++++++++++++++
 tb/tb_cache_param.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_param_if.sv
// cache_param_if: CPU-side 32-bit word port and memory-side 256-bit line port of cache_param.
// The slave modport is the cache's view; master is the requester/memory-model view.
interface cache_param_if;
    logic [31:0]  mem_address;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;

    modport slave (
        input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_wdata, pmem_read, pmem_write
    );

    modport master (
        output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write
    );
endinterface

// File: rtl/cache_param.sv
// cache_param: WAYS-way set-associative write-back/write-allocate cache, 256-bit lines, tree PLRU.
// Hit/miss counters are built only when CACHE_PARAM_PERF_EN is defined.
module cache_param #(
    parameter int unsigned S_INDEX = 3,
    parameter int unsigned WAYS    = 4
) (
    input  logic         clk,
    input  logic         rst,
    cache_param_if.slave bus
`ifdef CACHE_PARAM_PERF_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int unsigned SETS  = 1 << S_INDEX;
    localparam int unsigned TAG_W = 27 - S_INDEX;
    localparam int unsigned WAY_W = $clog2(WAYS);

    if (WAYS != 2 && WAYS != 4 && WAYS != 8) begin : g_bad_ways
        $error("cache_param: WAYS must be 2, 4 or 8");
    end

    // StFillWr holds the registered fill beat for one cycle before it lands in the arrays.
    typedef enum logic [2:0] {StIdle, StCheck, StWb, StFill, StFillWr} state_e;
    state_e state_q, state_d;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [WAYS-2:0]  plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [255:0]     data_q  [SETS][WAYS];
    logic [255:0]     fill_q;
    logic [WAY_W-1:0] victim_q;

    logic [TAG_W-1:0]   tag;
    logic [S_INDEX-1:0] index;
    logic [7:0]         word_off;

    assign tag      = bus.mem_address[31:5+S_INDEX];
    assign index    = bus.mem_address[4+S_INDEX:5];
    assign word_off = {bus.mem_address[4:2], 5'b00000};

    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[index][w] && (tag_q[index][w] == tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
        hit = $onehot(hit_vec);
    end

    assign bus.mem_rdata = data_q[index][hit_way][word_off +: 32];

    // Lowest invalid way first; otherwise follow the tree bits (1 = go right).
    logic [WAY_W-1:0] victim_way;
    always_comb begin
        int   node;
        int   v;
        logic found;
        node       = 0;
        v          = 0;
        found      = 1'b0;
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[index][w]) begin
                found      = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        if (!found) begin
            for (int l = 0; l < WAY_W; l++) begin
                v    = 2 * v + int'(plru_q[index][node]);
                node = 2 * node + 1 + int'(plru_q[index][node]);
            end
            victim_way = WAY_W'(v);
        end
    end

    // On an access every node on the path is pointed at the other subtree.
    logic [WAYS-2:0] plru_upd;
    always_comb begin
        int   node;
        logic b;
        node     = 0;
        b        = 1'b0;
        plru_upd = plru_q[index];
        for (int l = 0; l < WAY_W; l++) begin
            b              = hit_way[WAY_W-1-l];
            plru_upd[node] = ~b;
            node           = 2 * node + 1 + int'(b);
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {tag, index, 5'b00000};
        bus.pmem_wdata   = data_q[index][victim_q];
        unique case (state_q)
            StIdle: begin
                if (bus.mem_read || bus.mem_write) state_d = StCheck;
            end
            StCheck: begin
                if (hit) begin
                    bus.mem_resp = 1'b1;
                    state_d      = StIdle;
                end else if (valid_q[index][victim_way] && dirty_q[index][victim_way]) begin
                    state_d = StWb;
                end else begin
                    state_d = StFill;
                end
            end
            StWb: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q[index][victim_q], index, 5'b00000};
                if (bus.pmem_resp) state_d = StFill;
            end
            StFill: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) state_d = StFillWr;
            end
            StFillWr: state_d = StCheck;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == StCheck) begin
                if (hit) begin
                    plru_q[index] <= plru_upd;
                    if (bus.mem_write && (bus.mem_byte_enable != 4'b0000)) begin
                        dirty_q[index][hit_way] <= 1'b1;
                    end
                end else begin
                    victim_q <= victim_way;
                end
            end
            if (state_q == StWb && bus.pmem_resp) dirty_q[index][victim_q] <= 1'b0;
            if (state_q == StFillWr) begin
                valid_q[index][victim_q] <= 1'b1;
                dirty_q[index][victim_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StFill && bus.pmem_resp) fill_q <= bus.pmem_rdata;
            if (state_q == StFillWr) begin
                data_q[index][victim_q] <= fill_q;
                tag_q[index][victim_q]  <= tag;
            end
            if (state_q == StCheck && hit && bus.mem_write) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.mem_byte_enable[i]) begin
                        data_q[index][hit_way][word_off + 8'(8 * i) +: 8] <= bus.mem_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef CACHE_PARAM_PERF_EN
    logic        from_fill_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // The hit that completes a miss is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            from_fill_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            from_fill_q <= (state_q == StFillWr);
            if (state_q == StCheck) begin
                if (hit && !from_fill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
                else if (!hit)           miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_param.sv
// tb_cache_param: directed table, corner sequences and random traffic for cache_param
// against a flat word-memory model and a line-memory responder.
module tb_cache_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_param_if bus();
`ifdef CACHE_PARAM_PERF_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_param #(.S_INDEX(3), .WAYS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CACHE_PARAM_PERF_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    localparam int LIMIT = 200;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int mem_lat = 1;
    int resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
        int          cyc;
    } pm_t;
    pm_t log_q[$];

    logic [255:0] back_mem [logic [26:0]];
    logic [31:0]  ref_mem  [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEAD_BEEF;
        if (a == 32'h44) return 32'hAAAA_AAAA;
        return {~a[15:0], a[15:0]} ^ 32'h1357_2468;
    endfunction

    function automatic logic [255:0] line_get(input logic [26:0] ln);
        logic [255:0] l;
        if (back_mem.exists(ln)) return back_mem[ln];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({ln, 5'b00000} + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [255:0] l;
        if (ref_mem.exists(a)) return ref_mem[a];
        l = line_get(a[31:5]);
        return l[int'(a[4:2]) * 32 +: 32];
    endfunction

    function automatic int count_wr();
        int n = 0;
        foreach (log_q[i]) if (log_q[i].wr) n++;
        return n;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-memory responder: answers pmem_read/pmem_write after mem_lat cycles.
    initial begin
        int wait_left;
        wait_left      = -1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (rst || !(bus.pmem_read || bus.pmem_write)) begin
                wait_left = -1;
            end else begin
                if (wait_left < 0) wait_left = mem_lat;
                if (wait_left == 0) begin
                    if (bus.pmem_write) begin
                        back_mem[bus.pmem_address[31:5]] = bus.pmem_wdata;
                        log_q.push_back('{1'b1, bus.pmem_address, bus.pmem_wdata, cyc});
                    end else begin
                        bus.pmem_rdata = line_get(bus.pmem_address[31:5]);
                        log_q.push_back('{1'b0, bus.pmem_address, bus.pmem_rdata, cyc});
                    end
                    bus.pmem_resp = 1'b1;
                    wait_left     = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns lat=cycles to mem_resp (0 on timeout).
    task automatic cpu_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, output logic [31:0] rd, output int lat);
        logic [31:0] cur;
        bus.mem_address     = a;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        lat = 0;
        rd  = 'x;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) begin
                lat      = i;
                rd       = bus.mem_rdata;
                resp_cyc = cyc;
                break;
            end
        end
        check($sformatf("resp within bound @%0h", a), lat != 0, 1'b1);
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (wr && lat != 0) begin
            cur = ref_word(a);
            for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
            ref_mem[a] = cur;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ref_mem.delete();
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input bit exp_hit);
        logic [31:0] rd;
        logic [31:0] exp;
        int lat;
        exp = ref_word(a);
        cpu_access(1'b0, a, 32'h0, 4'h0, rd, lat);
        check({name, " rdata"}, rd, exp);
        check({name, " hit"}, lat == 1, exp_hit);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        bit          chk_rd;
        bit          exp_hit;
    } vec_t;
    localparam int NV = 11;
    vec_t vecs[NV];

    initial begin
        logic [31:0]  rd;
        logic [31:0]  tmp;
        logic [255:0] exp_line;
        int lat;
        int n0;
        bit seen;

        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        do_reset();
        check("reset mem_resp", bus.mem_resp, 1'b0);
        check("reset pmem_read", bus.pmem_read, 1'b0);
        check("reset pmem_write", bus.pmem_write, 1'b0);

        // Directed table on a freshly reset cache.
        tmp = init_word(32'h60);
        tmp[31:24] = 8'h77;
        vecs[0]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'hDEAD_BEEF,     1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h44, 32'h1122_3344, 4'h5, 32'h0,             1'b0, 1'b1};
        vecs[2]  = '{1'b0, 32'h44, 32'h0,         4'h0, 32'hAA22_AA44,     1'b1, 1'b1};
        vecs[3]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'hDEAD_BEEF,     1'b1, 1'b1};
        vecs[4]  = '{1'b1, 32'h5C, 32'hCAFE_F00D, 4'hF, 32'h0,             1'b0, 1'b1};
        vecs[5]  = '{1'b0, 32'h5C, 32'h0,         4'h0, 32'hCAFE_F00D,     1'b1, 1'b1};
        vecs[6]  = '{1'b1, 32'h48, 32'hFFFF_FFFF, 4'h0, 32'h0,             1'b0, 1'b1};
        vecs[7]  = '{1'b0, 32'h48, 32'h0,         4'h0, init_word(32'h48), 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'h60, 32'h0,         4'h0, init_word(32'h60), 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h60, 32'h7700_0000, 4'h8, 32'h0,             1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h60, 32'h0,         4'h0, tmp,               1'b1, 1'b1};
        log_q.delete();
        mem_lat = 2;
        for (int i = 0; i < NV; i++) begin
            cpu_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat);
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d hit", i), lat == 1, vecs[i].exp_hit);
            if (!vecs[i].exp_hit) begin
                check($sformatf("vec%0d fill tail", i),
                      resp_cyc - ((log_q.size() > 0) ? log_q[$].cyc : -100), 2);
            end
        end
        check("cold fill count", log_q.size(), 2);
        check("cold fill addr", (log_q.size() > 0) ? log_q[0].addr : 32'hFFFF_FFFF, 32'h40);
        check("table no writeback", count_wr(), 0);

        // Five tags in set 2: the fifth write evicts 0x040 (dirty) then fills 0x440.
        do_reset();
        log_q.delete();
        for (int t = 0; t < 4; t++) begin
            cpu_access(1'b1, 32'h40 + 32'(t) * 32'h100, 32'h0BAD_0000 + 32'(t), 4'hF, rd, lat);
        end
        exp_line = line_get(27'h2);
        exp_line[31:0] = 32'h0BAD_0000;
        cpu_access(1'b1, 32'h440, 32'h0BAD_0004, 4'hF, rd, lat);
        check("5tag pmem count", log_q.size(), 6);
        if (log_q.size() == 6) begin
            check("5tag wb is write", log_q[4].wr, 1'b1);
            check("5tag wb addr", log_q[4].addr, 32'h40);
            check("5tag wb data", log_q[4].data, exp_line);
            check("5tag fill is read", log_q[5].wr, 1'b0);
            check("5tag fill addr", log_q[5].addr, 32'h440);
        end
        read_chk("5tag reread 0x040", 32'h40, 1'b0);

        // PLRU: after filling ways 0..3 and touching way 0, the next miss evicts way 2.
        do_reset();
        log_q.delete();
        mem_lat = 1;
        for (int t = 0; t < 4; t++) read_chk($sformatf("plru fill %0d", t), 32'(t) * 32'h100, 1'b0);
        read_chk("plru touch way0", 32'h000, 1'b1);
        read_chk("plru miss 0x400", 32'h400, 1'b0);
        read_chk("plru keep 0x000", 32'h000, 1'b1);
        read_chk("plru keep 0x100", 32'h100, 1'b1);
        read_chk("plru keep 0x300", 32'h300, 1'b1);
        read_chk("plru evicted 0x200", 32'h200, 1'b0);

        // A zero-enable store must not make the line dirty.
        do_reset();
        log_q.delete();
        read_chk("be0 fill", 32'h80, 1'b0);
        cpu_access(1'b1, 32'h80, 32'hFFFF_FFFF, 4'h0, rd, lat);
        check("be0 store hit", lat, 1);
        for (int t = 1; t <= 4; t++) read_chk($sformatf("be0 evict %0d", t), 32'h80 + 32'(t) * 32'h100, 1'b0);
        check("be0 no writeback", count_wr(), 0);

        // Reset while FILL is waiting on memory.
        do_reset();
        log_q.delete();
        mem_lat = 30;
        bus.mem_address = 32'hA0;
        bus.mem_read    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < LIMIT && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus.pmem_read;
        end
        check("midfill reached fill", seen, 1'b1);
        rst          = 1'b1;
        bus.mem_read = 1'b0;
        @(posedge clk);
        #1;
        check("midfill pmem_read dropped", bus.pmem_read, 1'b0);
        check("midfill pmem_write low", bus.pmem_write, 1'b0);
        check("midfill mem_resp low", bus.mem_resp, 1'b0);
        rst = 1'b0;
        ref_mem.delete();
        mem_lat = 1;
        n0 = log_q.size();
        read_chk("midfill reread", 32'hA0, 1'b0);
        check("midfill refetch", log_q.size(), n0 + 1);

`ifdef CACHE_PARAM_PERF_EN
        do_reset();
        check("perf reset hits", hit_count, 32'd0);
        check("perf reset misses", miss_count, 32'd0);
        read_chk("perf miss", 32'h80, 1'b0);
        for (int t = 0; t < 3; t++) read_chk($sformatf("perf hit %0d", t), 32'h80, 1'b1);
        check("perf miss_count", miss_count, 32'd1);
        check("perf hit_count", hit_count, 32'd3);
`endif

        // Random traffic over a few tags in four sets against the flat memory model.
        do_reset();
        log_q.delete();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] exp;
            logic [3:0]  be;
            bit          wr;
            a  = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 5) |
                 (32'($urandom_range(0, 7)) << 2);
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            be = 4'($urandom);
            mem_lat = $urandom_range(0, 3);
            exp = ref_word(a);
            cpu_access(wr, a, wd, be, rd, lat);
            if (!wr) check($sformatf("rand%0d read %0h", n, a), rd, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
